regfile_writeback_queue: RTL and testbench
==========================================

Name: regfile_writeback_queue

Overview:
- Write-side companion of the register file: buffers result write-backs from the ALU and load paths and drives the register file write port.
- Retires at most one entry per cycle.
- Provides a read-bypass lookup so decode sees pending (not yet committed) register values.
- Sits between the execute/memory stages and register_file.

Parameters:
- WORD_SIZE, 16, data width of a register.
- REG_ADDR_W, 2, width of a register index.
- NUM_REG, 4, number of architectural registers; indices >= NUM_REG are invalid.
- DEPTH, 4, queue entries; must be a power of two, >= 2.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers a write-back this cycle.
- in_ready  output  1  queue can accept; transfer occurs when in_valid && in_ready at posedge.
- in_reg  input  REG_ADDR_W  destination register index.
- in_data  input  WORD_SIZE  value to write.
- drain_en  input  1  1 = allowed to retire an entry this cycle; 0 = stall retirement.
- reg_write  output  1  write strobe to register_file.
- write_reg  output  REG_ADDR_W  register_file write index.
- write_data  output  WORD_SIZE  register_file write data.
- lookup_reg  input  REG_ADDR_W  register index queried by decode.
- lookup_hit  output  1  a pending write to lookup_reg exists.
- lookup_data  output  WORD_SIZE  value of the youngest pending write to lookup_reg; 0 when no hit.
- empty  output  1  queue empty and no write in flight.

Behaviour:
- Reset (reset_n=0, async): count=0, head=tail=0, reg_write=0, write_reg=0, write_data=0, in_ready=1, empty=1, lookup_hit=0. All pending entries are discarded, including mid-drain; nothing reaches the register file.
- Storage: circular buffer of DEPTH {reg, data} entries. Head/tail pointers wrap modulo DEPTH. count is 0..DEPTH.
- in_ready = (count != DEPTH), derived combinationally from registered count only.
- When full, in_ready=0 even if a pop happens that same cycle (no same-cycle refill).
- in_valid while full: ignored, no state change.
- Push at posedge when in_valid && in_ready: write the entry at tail, tail+1.
- Pop at posedge when count != 0 && drain_en: remove the head entry and load it into the output registers (write_reg, write_data); head+1.
  - reg_write=1 if the entry's reg < NUM_REG.
  - reg_write=0 for an invalid index: the entry is dropped silently, but it still consumes the retire slot.
- At any posedge without a pop: reg_write=0. write_reg and write_data hold their last values.
- Outputs are registered and stable for a full cycle. register_file commits on the following negedge.
- Simultaneous push and pop: count unchanged; both pointers advance.
- A push into an empty queue cannot retire on the same edge. Minimum latency: push at edge N, reg_write high from edge N+1 to N+2, committed at the negedge between them.
- Bypass (combinational): search the queue entries plus the output stage (when reg_write=1) for reg == lookup_reg.
  - Priority: youngest queue entry first, then older entries, then the output stage.
  - Invalid-index entries never hit.
- empty = (count==0) && !reg_write.

Decomposition:
- Shared package/header: WORD_SIZE, REG_ADDR_W, NUM_REG defaults (same header as the register file); a queue-entry struct/bundle {reg, data}.
- One natural sub-module: wbq_bypass_search, a purely combinational youngest-match priority search over the entry array, head pointer and count. The top level holds the FIFO, pointers and output stage.

Test Plan:
- Reset values: assert reset_n=0 mid-cycle -> immediately reg_write=0, write_reg=0, write_data=0, in_ready=1, empty=1. Release, then idle 3 cycles -> no writes.
- Single write: push (reg=2, data=16'h1234) at edge 1 with drain_en=1 -> reg_write=1, write_reg=2, write_data=16'h1234 during cycle 2 only. Register file r[2]=16'h1234 after the negedge. empty=1 from edge 3.
- Full/overflow: drain_en=0, push 5 entries (data 1..5) -> in_ready=0 after 4th accept, 5th ignored. Set drain_en=1 -> retires 1,2,3,4 in order on consecutive cycles. Data 5 is never written.
- Bypass priority: drain_en=0, push (r1,16'hAAAA) then (r1,16'hBBBB), lookup_reg=1 -> hit=1, data=16'hBBBB. lookup_reg=3 -> hit=0, data=0.
- Wrap-around with concurrent push/pop: DEPTH=4, stream 10 writes with drain_en toggling 1,0,1,... -> all 10 retire in order with correct index/data. count never exceeds 4. Pointers wrap twice.
- Reset mid-operation: 3 entries queued and one retiring, pulse reset_n low -> reg_write drops asynchronously. After release, no stale entry is ever written and lookup_hit=0 for all indices.

Source files
------------

// File: rtl/regfile_writeback_queue_pkg.sv
// Shared register-file definitions and the write-back queue entry layout.
// Same widths the register file itself uses.
package regfile_writeback_queue_pkg;

    localparam int WORD_SIZE  = 16;
    localparam int REG_ADDR_W = 2;
    localparam int NUM_REG    = 4;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] reg_idx;
        logic [WORD_SIZE-1:0]  data;
    } wbq_entry_t;

    // Zero-extend so the compare stays meaningful when NUM_REG == 2**REG_ADDR_W.
    function automatic logic reg_is_valid(input logic [REG_ADDR_W-1:0] r);
        return {1'b0, r} < (REG_ADDR_W+1)'(NUM_REG);
    endfunction

endpackage

// File: rtl/regfile_writeback_queue_bypass_search.sv
// Youngest-match search over the pending write-back entries and the output stage.
// Purely combinational; feeds the decode-side bypass.
module wbq_bypass_search
    import regfile_writeback_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  wbq_entry_t             entries [DEPTH],
    input  logic [PTR_W-1:0]       head,
    input  logic [CNT_W-1:0]       count,
    input  logic                   out_valid,
    input  logic [REG_ADDR_W-1:0]  out_reg,
    input  logic [WORD_SIZE-1:0]   out_data,
    input  logic [REG_ADDR_W-1:0]  lookup_reg,
    output logic                   hit,
    output logic [WORD_SIZE-1:0]   data
);

    logic [PTR_W-1:0] idx;

    // Oldest to youngest, so a later match overrides an earlier one.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        if (out_valid && (out_reg == lookup_reg)) begin
            hit  = 1'b1;
            data = out_data;
        end
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) &&
                reg_is_valid(entries[idx].reg_idx) &&
                (entries[idx].reg_idx == lookup_reg)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Write-back queue in front of the register file write port: circular buffer,
// one retirement per cycle through a registered output stage, plus read bypass.
module regfile_writeback_queue
    import regfile_writeback_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [REG_ADDR_W-1:0]  in_reg,
    input  logic [WORD_SIZE-1:0]   in_data,
    input  logic                   drain_en,
    output logic                   reg_write,
    output logic [REG_ADDR_W-1:0]  write_reg,
    output logic [WORD_SIZE-1:0]   write_data,
    input  logic [REG_ADDR_W-1:0]  lookup_reg,
    output logic                   lookup_hit,
    output logic [WORD_SIZE-1:0]   lookup_data,
    output logic                   empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wbq_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             push;
    logic             pop;

    // Ready depends only on the registered count: a full queue never refills
    // on the same edge it retires.
    assign in_ready = (count != CNT_W'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = (count != '0) && drain_en;
    assign empty    = (count == '0) && !reg_write;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            reg_write  <= 1'b0;
            write_reg  <= '0;
            write_data <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[tail] <= '{reg_idx: in_reg, data: in_data};
                tail      <= tail + PTR_W'(1);
            end

            // Invalid-index entries still use the retire slot but never strobe.
            reg_write <= 1'b0;
            if (pop) begin
                reg_write  <= reg_is_valid(mem[head].reg_idx);
                write_reg  <= mem[head].reg_idx;
                write_data <= mem[head].data;
                head       <= head + PTR_W'(1);
            end

            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    wbq_bypass_search #(
        .DEPTH (DEPTH)
    ) u_bypass (
        .entries    (mem),
        .head       (head),
        .count      (count),
        .out_valid  (reg_write),
        .out_reg    (write_reg),
        .out_data   (write_data),
        .lookup_reg (lookup_reg),
        .hit        (lookup_hit),
        .data       (lookup_data)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Self-checking bench for regfile_writeback_queue against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  in_reg;
    logic [15:0] in_data;
    logic        drain_en;
    logic        reg_write;
    logic [1:0]  write_reg;
    logic [15:0] write_data;
    logic [1:0]  lookup_reg;
    logic        lookup_hit;
    logic [15:0] lookup_data;
    logic        empty;

    always #5 clk = ~clk;

    regfile_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_reg      (in_reg),
        .in_data     (in_data),
        .drain_en    (drain_en),
        .reg_write   (reg_write),
        .write_reg   (write_reg),
        .write_data  (write_data),
        .lookup_reg  (lookup_reg),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .empty       (empty)
    );

    // Register file as seen through the DUT's write port (commits on negedge).
    logic [15:0] dut_rf [4];
    always @(negedge clk) begin
        if (reg_write === 1'b1) dut_rf[write_reg] <= write_data;
    end

    typedef struct {
        logic [1:0]  r;
        logic [15:0] d;
    } ent_t;

    ent_t        q[$];
    logic        m_wr;
    logic [1:0]  m_reg;
    logic [15:0] m_data;
    logic [15:0] m_rf [4];
    int          max_seen;
    int          n_tests;
    int          n_fail;

    function automatic bit reg_ok(input logic [1:0] r);
        return int'(r) < 4;
    endfunction

    // Youngest pending write first, then the value sitting on the write port.
    function automatic void exp_lookup(input logic [1:0] lk, output logic h, output logic [15:0] d);
        h = 1'b0;
        d = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (reg_ok(q[i].r) && q[i].r == lk) begin
                h = 1'b1;
                d = q[i].d;
                return;
            end
        end
        if (m_wr && m_reg == lk) begin
            h = 1'b1;
            d = m_data;
        end
    endfunction

    task automatic model_reset();
        q.delete();
        m_wr   = 1'b0;
        m_reg  = '0;
        m_data = '0;
    endtask

    task automatic drive(input logic v, input logic [1:0] r, input logic [15:0] d,
                         input logic de, input logic [1:0] lk);
        in_valid   = v;
        in_reg     = r;
        in_data    = d;
        drain_en   = de;
        lookup_reg = lk;
    endtask

    // One clock edge: advance the reference model with the currently driven inputs.
    task automatic tick();
        ent_t e;
        bit   push;
        bit   pop;
        push = in_valid && (q.size() < DEPTH);
        pop  = (q.size() != 0) && drain_en;
        @(posedge clk);
        m_wr = 1'b0;
        if (pop) begin
            e      = q.pop_front();
            m_wr   = reg_ok(e.r);
            m_reg  = e.r;
            m_data = e.d;
            if (m_wr) m_rf[e.r] = e.d;
        end
        if (push) begin
            e.r = in_reg;
            e.d = in_data;
            q.push_back(e);
        end
        if (q.size() > max_seen) max_seen = q.size();
        #1;
    endtask

    task automatic drain_all();
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        for (int i = 0; i < 20 && (q.size() != 0 || m_wr); i++) tick();
        tick();
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd0);
        model_reset();
        #7 reset_n = 1'b1;
        drive(1'b1, 2'd3, 16'hBEEF, 1'b1, 2'd3);
        tick();
        drive(1'b1, 2'd1, 16'h0101, 1'b1, 2'd3);
        tick();
        n_tests++;
        if (reg_write !== 1'b1) begin
            n_fail++; $display("FAIL reset_pre_write: reg_write=%b expected 1", reg_write);
        end
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (reg_write !== 1'b0 || write_reg !== 2'd0 || write_data !== 16'h0 ||
            in_ready !== 1'b1 || empty !== 1'b1 || lookup_hit !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_async: wr=%b reg=%0d data=%h rdy=%b empty=%b hit=%b expected 0 0 0000 1 1 0",
                     reg_write, write_reg, write_data, in_ready, empty, lookup_hit);
        end
        #2 reset_n = 1'b1;
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (reg_write !== 1'b0 || empty !== 1'b1) begin
                n_fail++; $display("FAIL reset_idle[%0d]: wr=%b empty=%b expected 0 1", i, reg_write, empty);
            end
        end
    endtask

    task automatic test_single_write();
        drive(1'b1, 2'd2, 16'h1234, 1'b1, 2'd2);
        tick();
        n_tests++;
        if (reg_write !== 1'b0 || lookup_hit !== 1'b1 || lookup_data !== 16'h1234 || empty !== 1'b0) begin
            n_fail++; $display("FAIL single_edge1: wr=%b hit=%b data=%h empty=%b expected 0 1 1234 0",
                               reg_write, lookup_hit, lookup_data, empty);
        end
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd2);
        tick();
        n_tests++;
        if (reg_write !== 1'b1 || write_reg !== 2'd2 || write_data !== 16'h1234 || empty !== 1'b0) begin
            n_fail++; $display("FAIL single_edge2: wr=%b reg=%0d data=%h empty=%b expected 1 2 1234 0",
                               reg_write, write_reg, write_data, empty);
        end
        @(negedge clk); #1;
        n_tests++;
        if (dut_rf[2] !== 16'h1234) begin
            n_fail++; $display("FAIL single_commit: r2=%h expected 1234", dut_rf[2]);
        end
        tick();
        n_tests++;
        if (reg_write !== 1'b0 || empty !== 1'b1) begin
            n_fail++; $display("FAIL single_edge3: wr=%b empty=%b expected 0 1", reg_write, empty);
        end
    endtask

    task automatic test_overflow();
        for (int k = 1; k <= 5; k++) begin
            drive(1'b1, 2'((k - 1) % 4), 16'(k), 1'b0, 2'd0);
            tick();
            n_tests++;
            if (in_ready !== (k < 4)) begin
                n_fail++; $display("FAIL overflow_ready[%0d]: in_ready=%b expected %b", k, in_ready, k < 4);
            end
        end
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        for (int k = 1; k <= 5; k++) begin
            tick();
            n_tests++;
            if (k <= 4) begin
                if (reg_write !== 1'b1 || write_data !== 16'(k) || write_reg !== 2'((k - 1) % 4)) begin
                    n_fail++; $display("FAIL overflow_retire[%0d]: wr=%b reg=%0d data=%h expected 1 %0d %h",
                                       k, reg_write, write_reg, write_data, (k - 1) % 4, 16'(k));
                end
            end else if (reg_write !== 1'b0) begin
                n_fail++; $display("FAIL overflow_no5: wr=%b data=%h expected wr 0", reg_write, write_data);
            end
        end
    endtask

    task automatic test_bypass_priority();
        logic        eh;
        logic [15:0] ed;
        drive(1'b1, 2'd1, 16'hAAAA, 1'b0, 2'd1);
        tick();
        drive(1'b1, 2'd1, 16'hBBBB, 1'b0, 2'd1);
        tick();
        drive(1'b0, 2'd0, 16'h0, 1'b0, 2'd1);
        #1;
        n_tests++;
        if (lookup_hit !== 1'b1 || lookup_data !== 16'hBBBB) begin
            n_fail++; $display("FAIL bypass_youngest: hit=%b data=%h expected 1 bbbb", lookup_hit, lookup_data);
        end
        lookup_reg = 2'd3;
        #1;
        n_tests++;
        if (lookup_hit !== 1'b0 || lookup_data !== 16'h0) begin
            n_fail++; $display("FAIL bypass_miss: hit=%b data=%h expected 0 0000", lookup_hit, lookup_data);
        end
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            exp_lookup(2'd1, eh, ed);
            n_tests++;
            if (lookup_hit !== eh || lookup_data !== ed) begin
                n_fail++; $display("FAIL bypass_drain[%0d]: hit=%b data=%h expected %b %h",
                                   i, lookup_hit, lookup_data, eh, ed);
            end
        end
    endtask

    task automatic test_wrap();
        int sent = 0;
        int nret = 0;
        max_seen = 0;
        for (int cyc = 0; cyc < 200 && nret < 10; cyc++) begin
            drive(sent < 10, 2'(sent % 4), 16'h0100 + 16'(sent), (cyc % 2) == 0, 2'd0);
            if (in_valid && q.size() < DEPTH) begin
                tick();
                sent++;
            end else begin
                tick();
            end
            n_tests++;
            if (in_ready !== (q.size() != DEPTH) || reg_write !== m_wr) begin
                n_fail++; $display("FAIL wrap_ctrl[%0d]: rdy=%b wr=%b expected %b %b",
                                   cyc, in_ready, reg_write, q.size() != DEPTH, m_wr);
            end
            if (m_wr) begin
                n_tests++;
                if (write_data !== 16'h0100 + 16'(nret) || write_reg !== 2'(nret % 4)) begin
                    n_fail++; $display("FAIL wrap_order[%0d]: reg=%0d data=%h expected %0d %h",
                                       nret, write_reg, write_data, nret % 4, 16'h0100 + 16'(nret));
                end
                nret++;
            end
        end
        n_tests++;
        if (nret != 10 || max_seen > DEPTH) begin
            n_fail++; $display("FAIL wrap_total: retired=%0d max_count=%0d expected 10 <=4", nret, max_seen);
        end
    endtask

    task automatic test_random();
        logic        eh;
        logic [15:0] ed;
        for (int cyc = 0; cyc < 400; cyc++) begin
            drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
                  $urandom_range(0, 2) != 0, 2'($urandom_range(0, 3)));
            tick();
            exp_lookup(lookup_reg, eh, ed);
            n_tests++;
            if (reg_write !== m_wr || write_reg !== m_reg || write_data !== m_data ||
                in_ready !== (q.size() != DEPTH) || empty !== (q.size() == 0 && !m_wr) ||
                lookup_hit !== eh || lookup_data !== ed) begin
                n_fail++;
                $display("FAIL random[%0d]: wr=%b reg=%0d data=%h rdy=%b empty=%b hit=%b ldata=%h expected %b %0d %h %b %b %b %h",
                         cyc, reg_write, write_reg, write_data, in_ready, empty, lookup_hit, lookup_data,
                         m_wr, m_reg, m_data, q.size() != DEPTH, q.size() == 0 && !m_wr, eh, ed);
            end
        end
        drain_all();
        @(negedge clk); #1;
        for (int r = 0; r < 4; r++) begin
            n_tests++;
            if (dut_rf[r] !== m_rf[r]) begin
                n_fail++; $display("FAIL random_rf[%0d]: value=%h expected %h", r, dut_rf[r], m_rf[r]);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 16'hC000 + 16'(k), 1'b0, 2'd0);
            tick();
        end
        drive(1'b0, 2'd0, 16'h0, 1'b1, 2'd0);
        tick();
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        n_tests++;
        if (reg_write !== 1'b0 || empty !== 1'b1 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL midreset_async: wr=%b empty=%b rdy=%b expected 0 1 1",
                               reg_write, empty, in_ready);
        end
        #2 reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            n_tests++;
            if (reg_write !== 1'b0) begin
                n_fail++; $display("FAIL midreset_stale[%0d]: wr=%b reg=%0d data=%h expected wr 0",
                                   i, reg_write, write_reg, write_data);
            end
        end
        for (int r = 0; r < 4; r++) begin
            lookup_reg = 2'(r);
            #1;
            n_tests++;
            if (lookup_hit !== 1'b0) begin
                n_fail++; $display("FAIL midreset_lookup[%0d]: hit=%b expected 0", r, lookup_hit);
            end
        end
    endtask

    initial begin
        n_tests  = 0;
        n_fail   = 0;
        max_seen = 0;
        for (int r = 0; r < 4; r++) begin
            dut_rf[r] = '0;
            m_rf[r]   = '0;
        end
        test_reset();
        test_single_write();
        drain_all();
        test_overflow();
        drain_all();
        test_bypass_priority();
        drain_all();
        test_wrap();
        drain_all();
        test_random();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
